// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and field layout for pipe_skid_stage and its callers.
//   state_e      - stage state; the encoding doubles as the occupancy count.
//   IDEX_*       - bit offsets/widths of the ID/EX payload inside data_in/data_out.
//   idex_t       - packed view of the same ID/EX layout (pc in the MSBs).
package pipe_pkg;

    // Stage state; numeric value equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // ID/EX field widths.
    localparam int unsigned IDEX_PC_W   = 32;
    localparam int unsigned IDEX_RS1_W  = 5;
    localparam int unsigned IDEX_RS2_W  = 5;
    localparam int unsigned IDEX_RD_W   = 5;
    localparam int unsigned IDEX_RD1_W  = 32;
    localparam int unsigned IDEX_RD2_W  = 32;
    localparam int unsigned IDEX_IMM_W  = 32;
    localparam int unsigned IDEX_CTRL_W = 17;

    // ID/EX field LSB offsets, control in the low bits, pc at the top.
    localparam int unsigned IDEX_CTRL_LSB = 0;
    localparam int unsigned IDEX_IMM_LSB  = IDEX_CTRL_LSB + IDEX_CTRL_W;
    localparam int unsigned IDEX_RD2_LSB  = IDEX_IMM_LSB  + IDEX_IMM_W;
    localparam int unsigned IDEX_RD1_LSB  = IDEX_RD2_LSB  + IDEX_RD2_W;
    localparam int unsigned IDEX_RD_LSB   = IDEX_RD1_LSB  + IDEX_RD1_W;
    localparam int unsigned IDEX_RS2_LSB  = IDEX_RD_LSB   + IDEX_RD_W;
    localparam int unsigned IDEX_RS1_LSB  = IDEX_RS2_LSB  + IDEX_RS2_W;
    localparam int unsigned IDEX_PC_LSB   = IDEX_RS1_LSB  + IDEX_RS1_W;
    localparam int unsigned IDEX_W        = IDEX_PC_LSB   + IDEX_PC_W;

    // Packed ID/EX payload; member order matches the offsets above.
    typedef struct packed {
        logic [IDEX_PC_W-1:0]   pc;
        logic [IDEX_RS1_W-1:0]  rs1;
        logic [IDEX_RS2_W-1:0]  rs2;
        logic [IDEX_RD_W-1:0]   rd;
        logic [IDEX_RD1_W-1:0]  rd1;
        logic [IDEX_RD2_W-1:0]  rd2;
        logic [IDEX_IMM_W-1:0]  imm;
        logic [IDEX_CTRL_W-1:0] ctrl;
    } idex_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: generic valid/ready pipeline register with a 2-entry skid
// buffer and synchronous flush. in_ready is a flop, so there is no
// combinational path from out_ready to in_ready.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   flush            - synchronous kill of all held entries
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload
//   occupancy        - number of held entries (0..2)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = 160,
    parameter bit          ZERO_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              in_fire, out_fire;

    // Next-state and datapath selection.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        in_fire     = in_valid & in_ready_q;
        out_fire    = out_valid_q & out_ready;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    // Consumer stalled: park the new entry behind main.
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Drained stage presents a NOP bubble.
        if (ZERO_ON_EMPTY && (state_d == ST_EMPTY)) begin
            main_d = '0;
        end

        // Flush overrides everything; any same-cycle in_fire is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, payload and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = 2'(state_q);

endmodule
